// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller between an 8-bit RAM port and two word-level
// clients (instruction Fetcher and LoadStoreBuffer).
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   mem_din/mem_dout/mem_a/mem_wr
//                            RAM byte port; read data is valid one cycle after mem_a
//   io_buffer_full_in        stalls IO stores while high
//   if_request_in/if_address_in/if_ready_out/if_instruction_out
//                            fetch client: request pulse in, ready pulse + word out
//   lsb_request_in/lsb_rw_in/lsb_size_in/lsb_address_in/lsb_data_in
//   lsb_ready_out/lsb_data_out
//                            load/store client: request pulse in, ready pulse out
//   rob_rollback_in          squashes speculative reads (never stores or IO loads)
//
// Each request pulse is latched, arbitrated (LSB first) and split into
// little-endian byte transfers. All outputs are registered.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full_in,
  input  logic        if_request_in,
  input  logic [31:0] if_address_in,
  output logic        if_ready_out,
  output logic [31:0] if_instruction_out,
  input  logic        lsb_request_in,
  input  logic        lsb_rw_in,
  input  logic [1:0]  lsb_size_in,
  input  logic [31:0] lsb_address_in,
  input  logic [31:0] lsb_data_in,
  output logic        lsb_ready_out,
  output logic [31:0] lsb_data_out,
  input  logic        rob_rollback_in
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

  // Size 3 is illegal; it is treated like a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    unique case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        if_pend_q, if_pend_d;
  logic [31:0] if_addr_q, if_addr_d;
  logic        lsb_pend_q, lsb_pend_d;
  logic        lsb_rw_q, lsb_rw_d;
  logic [1:0]  lsb_size_q, lsb_size_d;
  logic [31:0] lsb_addr_q, lsb_addr_d;
  logic [31:0] lsb_wdata_q, lsb_wdata_d;

  // Access in flight
  logic        cur_lsb_q, cur_lsb_d;
  logic        cur_io_q, cur_io_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [2:0]  edge_q, edge_d;     // index of the coming edge, counted from accept
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [7:0]  mem_dout_q, mem_dout_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        lsb_ready_q, lsb_ready_d;
  logic [31:0] lsb_data_q, lsb_data_d;

  logic        busy_if, busy_lsb, lsb_blocked, lsb_squashable, lsb_go, if_go;
  logic [2:0]  rd_off;
  logic [1:0]  rd_idx;

  always_comb begin
    state_d     = state_q;
    if_pend_d   = if_pend_q;
    if_addr_d   = if_addr_q;
    lsb_pend_d  = lsb_pend_q;
    lsb_rw_d    = lsb_rw_q;
    lsb_size_d  = lsb_size_q;
    lsb_addr_d  = lsb_addr_q;
    lsb_wdata_d = lsb_wdata_q;
    cur_lsb_d   = cur_lsb_q;
    cur_io_d    = cur_io_q;
    base_d      = base_q;
    nbytes_d    = nbytes_q;
    edge_d      = edge_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_dout_d  = mem_dout_q;
    mem_a_d     = mem_a_q;
    mem_wr_d    = 1'b0;
    if_ready_d  = 1'b0;
    if_instr_d  = if_instr_q;
    lsb_ready_d = 1'b0;
    lsb_data_d  = lsb_data_q;

    busy_if        = (state_q != StIdle) && !cur_lsb_q;
    busy_lsb       = (state_q != StIdle) && cur_lsb_q;
    lsb_blocked    = lsb_rw_q && is_io(lsb_addr_q) && io_buffer_full_in;
    lsb_squashable = !lsb_rw_q && !is_io(lsb_addr_q);
    // A pending access that the same edge's rollback squashes is never accepted.
    lsb_go = (state_q == StIdle) && lsb_pend_q && !lsb_blocked &&
             !(rob_rollback_in && lsb_squashable);
    if_go  = (state_q == StIdle) && !lsb_go && if_pend_q && !rob_rollback_in;
    rd_off = edge_q - 3'd2;
    rd_idx = rd_off[1:0];

    // Request latches; pulses while pending or in flight are ignored.
    if (if_go) if_pend_d = 1'b0;
    if (if_request_in && !if_pend_q && !busy_if) begin
      if_pend_d = 1'b1;
      if_addr_d = if_address_in;
    end
    if (rob_rollback_in) if_pend_d = 1'b0;

    if (lsb_go) lsb_pend_d = 1'b0;
    if (lsb_request_in && !lsb_pend_q && !busy_lsb) begin
      lsb_pend_d  = 1'b1;
      lsb_rw_d    = lsb_rw_in;
      lsb_size_d  = lsb_size_in;
      lsb_addr_d  = lsb_address_in;
      lsb_wdata_d = lsb_data_in;
    end
    if (rob_rollback_in && lsb_pend_q && lsb_squashable) lsb_pend_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lsb_go) begin
          cur_lsb_d = 1'b1;
          cur_io_d  = is_io(lsb_addr_q);
          base_d    = lsb_addr_q;
          nbytes_d  = size_bytes(lsb_size_q);
          edge_d    = 3'd1;
          mem_a_d   = lsb_addr_q;
          rdata_d   = '0;
          if (lsb_rw_q) begin
            state_d    = StWrite;
            wdata_d    = lsb_wdata_q;
            mem_wr_d   = 1'b1;
            mem_dout_d = lsb_wdata_q[7:0];
          end else begin
            state_d = StRead;
          end
        end else if (if_go) begin
          cur_lsb_d = 1'b0;
          cur_io_d  = 1'b0;
          base_d    = if_addr_q;
          nbytes_d  = 3'd4;
          edge_d    = 3'd1;
          mem_a_d   = if_addr_q;
          rdata_d   = '0;
          state_d   = StRead;
        end
      end
      StRead: begin
        // IO loads must finish: the device has already consumed the data.
        if (rob_rollback_in && !(cur_lsb_q && cur_io_q)) begin
          state_d = StIdle;
        end else begin
          if (edge_q < nbytes_q) mem_a_d = base_q + {29'd0, edge_q};
          // Byte k arrives two edges after its address was driven.
          if (edge_q >= 3'd2) rdata_d[{rd_idx, 3'b000} +: 8] = mem_din;
          edge_d = edge_q + 3'd1;
          if (edge_q == nbytes_q + 3'd1) begin
            state_d = StIdle;
            if (cur_lsb_q) begin
              lsb_ready_d = 1'b1;
              lsb_data_d  = rdata_d;
            end else begin
              if_ready_d = 1'b1;
              if_instr_d = rdata_d;
            end
          end
        end
      end
      StWrite: begin
        if (edge_q < nbytes_q) begin
          mem_a_d    = base_q + {29'd0, edge_q};
          mem_dout_d = wdata_q[{edge_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          edge_d     = edge_q + 3'd1;
        end else begin
          state_d     = StIdle;
          lsb_ready_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      if_pend_q   <= 1'b0;
      if_addr_q   <= '0;
      lsb_pend_q  <= 1'b0;
      lsb_rw_q    <= 1'b0;
      lsb_size_q  <= '0;
      lsb_addr_q  <= '0;
      lsb_wdata_q <= '0;
      cur_lsb_q   <= 1'b0;
      cur_io_q    <= 1'b0;
      base_q      <= '0;
      nbytes_q    <= '0;
      edge_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_dout_q  <= '0;
      mem_a_q     <= '0;
      mem_wr_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      if_instr_q  <= '0;
      lsb_ready_q <= 1'b0;
      lsb_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      if_pend_q   <= if_pend_d;
      if_addr_q   <= if_addr_d;
      lsb_pend_q  <= lsb_pend_d;
      lsb_rw_q    <= lsb_rw_d;
      lsb_size_q  <= lsb_size_d;
      lsb_addr_q  <= lsb_addr_d;
      lsb_wdata_q <= lsb_wdata_d;
      cur_lsb_q   <= cur_lsb_d;
      cur_io_q    <= cur_io_d;
      base_q      <= base_d;
      nbytes_q    <= nbytes_d;
      edge_q      <= edge_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_dout_q  <= mem_dout_d;
      mem_a_q     <= mem_a_d;
      mem_wr_q    <= mem_wr_d;
      if_ready_q  <= if_ready_d;
      if_instr_q  <= if_instr_d;
      lsb_ready_q <= lsb_ready_d;
      lsb_data_q  <= lsb_data_d;
    end
  end

  assign mem_dout           = mem_dout_q;
  assign mem_a              = mem_a_q;
  assign mem_wr             = mem_wr_q;
  assign if_ready_out       = if_ready_q;
  assign if_instruction_out = if_instr_q;
  assign lsb_ready_out      = lsb_ready_q;
  assign lsb_data_out       = lsb_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized scenarios for mem_ctrl. A transaction-level
// scheduler predicts ready edges, read data and RAM writes from a byte-array
// memory image; observed events are compared against those predictions.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full_in;
  logic        if_request_in;
  logic [31:0] if_address_in;
  logic        if_ready_out;
  logic [31:0] if_instruction_out;
  logic        lsb_request_in;
  logic        lsb_rw_in;
  logic [1:0]  lsb_size_in;
  logic [31:0] lsb_address_in;
  logic [31:0] lsb_data_in;
  logic        lsb_ready_out;
  logic [31:0] lsb_data_out;
  logic        rob_rollback_in;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full_in (io_buffer_full_in),
    .if_request_in     (if_request_in),
    .if_address_in     (if_address_in),
    .if_ready_out      (if_ready_out),
    .if_instruction_out(if_instruction_out),
    .lsb_request_in    (lsb_request_in),
    .lsb_rw_in         (lsb_rw_in),
    .lsb_size_in       (lsb_size_in),
    .lsb_address_in    (lsb_address_in),
    .lsb_data_in       (lsb_data_in),
    .lsb_ready_out     (lsb_ready_out),
    .lsb_data_out      (lsb_data_out),
    .rob_rollback_in   (rob_rollback_in)
  );

  // Background contents of every byte, so untouched memory is not all zero.
  function automatic logic [7:0] hash_b(input logic [17:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd7 + (32'(a) >> 8) * 32'd13 + 32'h5A;
    return t[7:0];
  endfunction

  // Synchronous RAM (18-bit window); stores value ^ hash so a zero array reads as hash.
  logic [7:0]  ram [0:262143];
  bit          ram_init = 1'b0;
  logic        poke_en = 1'b0;
  logic [17:0] poke_a = '0;
  logic [7:0]  poke_d = '0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 262144; i++) ram[i] <= 8'h00;
      ram_init <= 1'b1;
    end else begin
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout ^ hash_b(mem_a[17:0]);
      if (poke_en) ram[poke_a] <= poke_d ^ hash_b(poke_a);
    end
    mem_din <= ram[mem_a[17:0]] ^ hash_b(mem_a[17:0]);
  end

  // Reference memory image
  logic [7:0] mref [0:262143];

  typedef struct {
    int          e;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t obs_if[$], obs_lsb[$], obs_wr[$];
  ev_t exp_if[$], exp_lsb[$], exp_wr[$];

  int          edge_n = 0;
  int          last_e0 = 0;
  logic [31:0] last_exp_if = '0;
  int          n_total = 0;
  int          n_bad = 0;

  always begin
    @(posedge clk);
    edge_n = edge_n + 1;
    #1;
    if (rst) begin
      if (if_ready_out)  obs_if.push_back('{edge_n, 32'd0, if_instruction_out});
      if (lsb_ready_out) obs_lsb.push_back('{edge_n, 32'd0, lsb_data_out});
      if (mem_wr)        obs_wr.push_back('{edge_n, mem_a, {24'd0, mem_dout}});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    logic [17:0] idx;
    idx = a[17:0];
    poke_a = idx;
    poke_d = d;
    poke_en = 1'b1;
    @(posedge clk);
    #2;
    poke_en = 1'b0;
    mref[idx] = d;
  endtask

  function automatic bit in_io(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] d, ad;
    logic [17:0] idx;
    d = '0;
    for (int k = 0; k < n; k++) begin
      ad = a + 32'(k);
      idx = ad[17:0];
      d[8*k +: 8] = mref[idx];
    end
    return d;
  endfunction

  // Issue requests (same edge), drive rollback/full windows, then compare with model.
  task automatic run_scn(input string name, input bit do_if, input logic [31:0] ia,
                         input bit do_lsb, input bit rw, input logic [1:0] sz,
                         input logic [31:0] la, input logic [31:0] ld,
                         input int rb_off, input int full_n);
    int e0, t, rb, acc, rdy, n;
    bit fw, lw, l_sq;
    logic [31:0] ad;
    logic [17:0] idx;
    obs_if.delete(); obs_lsb.delete(); obs_wr.delete();
    exp_if.delete(); exp_lsb.delete(); exp_wr.delete();
    @(posedge clk);
    #2;
    e0 = edge_n + 1;
    last_e0 = e0;
    for (int c = 0; c < 28; c++) begin
      if_request_in     = do_if && (c == 0);
      if_address_in     = ia;
      lsb_request_in    = do_lsb && (c == 0);
      lsb_rw_in         = rw;
      lsb_size_in       = sz;
      lsb_address_in    = la;
      lsb_data_in       = ld;
      rob_rollback_in   = (c == rb_off);
      io_buffer_full_in = (c < full_n);
      @(posedge clk);
      #2;
    end
    if_request_in = 1'b0; lsb_request_in = 1'b0;
    rob_rollback_in = 1'b0; io_buffer_full_in = 1'b0;

    // Scheduler model: one access at a time, LSB preferred, one idle edge between.
    rb   = (rb_off >= 0) ? e0 + rb_off : -1000;
    fw   = do_if && (rb != e0);
    lw   = do_lsb;
    l_sq = do_lsb && !rw && !in_io(la);
    n    = nbytes(sz);
    t    = e0 + 1;
    while ((fw || lw) && t < e0 + 60) begin
      if (t == rb) begin
        fw = 1'b0;
        if (l_sq) lw = 1'b0;
      end
      if (lw && !(rw && in_io(la) && t < e0 + full_n)) begin
        acc = t;
        rdy = acc + n + (rw ? 0 : 1);
        lw  = 1'b0;
        if (rb >= acc && rb <= rdy) fw = 1'b0;
        if (l_sq && rb >= acc && rb <= rdy) begin
          t = rb + 1;
        end else begin
          if (rw) begin
            for (int k = 0; k < n; k++) begin
              ad = la + 32'(k);
              idx = ad[17:0];
              exp_wr.push_back('{acc + k, ad, {24'd0, ld[8*k +: 8]}});
              mref[idx] = ld[8*k +: 8];
            end
            exp_lsb.push_back('{rdy, la, 32'd0});
          end else begin
            exp_lsb.push_back('{rdy, la, ref_read(la, n)});
          end
          t = rdy + 1;
        end
      end else if (fw) begin
        acc = t;
        rdy = acc + 5;
        fw  = 1'b0;
        if (rb >= acc && rb <= rdy) begin
          if (l_sq) lw = 1'b0;
          t = rb + 1;
        end else begin
          exp_if.push_back('{rdy, ia, ref_read(ia, 4)});
          last_exp_if = ref_read(ia, 4);
          t = rdy + 1;
        end
      end else begin
        t++;
      end
    end

    check_eq({name, "/if_cnt"}, obs_if.size(), exp_if.size());
    for (int i = 0; i < obs_if.size() && i < exp_if.size(); i++) begin
      check_eq({name, "/if_edge"}, obs_if[i].e, exp_if[i].e);
      check_eq({name, "/if_data"}, obs_if[i].d, exp_if[i].d);
    end
    check_eq({name, "/lsb_cnt"}, obs_lsb.size(), exp_lsb.size());
    for (int i = 0; i < obs_lsb.size() && i < exp_lsb.size(); i++) begin
      check_eq({name, "/lsb_edge"}, obs_lsb[i].e, exp_lsb[i].e);
      if (!rw) check_eq({name, "/lsb_data"}, obs_lsb[i].d, exp_lsb[i].d);
    end
    check_eq({name, "/wr_cnt"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      check_eq({name, "/wr_edge"}, obs_wr[i].e, exp_wr[i].e);
      check_eq({name, "/wr_addr"}, obs_wr[i].a, exp_wr[i].a);
      check_eq({name, "/wr_data"}, obs_wr[i].d, exp_wr[i].d);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6) return {14'd0, 18'($urandom)};
    if (sel < 8) return {14'($urandom), 2'b11, 16'($urandom)};
    return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] held;
    bit r_if, r_lsb, r_rw;
    logic [1:0] r_sz;
    int r_rb, r_full;

    for (int i = 0; i < 262144; i++) mref[i] = hash_b(18'(i));
    io_buffer_full_in = 1'b0; if_request_in = 1'b0; if_address_in = '0;
    lsb_request_in = 1'b0; lsb_rw_in = 1'b0; lsb_size_in = '0;
    lsb_address_in = '0; lsb_data_in = '0; rob_rollback_in = 1'b0;

    #3 rst = 1'b0;
    #1;
    check_eq("rst/mem_a", mem_a, 32'd0);
    check_eq("rst/mem_dout", {24'd0, mem_dout}, 32'd0);
    check_eq("rst/mem_wr", {31'd0, mem_wr}, 32'd0);
    check_eq("rst/if_ready", {31'd0, if_ready_out}, 32'd0);
    check_eq("rst/lsb_ready", {31'd0, lsb_ready_out}, 32'd0);
    check_eq("rst/if_instr", if_instruction_out, 32'd0);
    check_eq("rst/lsb_data", lsb_data_out, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);

    // Instruction fetch
    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
    run_scn("fetch", 1, 32'h1000, 0, 0, 2'd0, 0, 0, -1, 0);
    check_eq("fetch/instr", if_instruction_out, 32'h0000_0513);
    if (obs_if.size() > 0) check_eq("fetch/latency", obs_if[0].e - last_e0, 6);

    // Byte store
    run_scn("bstore", 0, 0, 1, 1, 2'd0, 32'h2004, 32'h0000_00AB, -1, 0);
    check_eq("bstore/ram", {24'd0, ram[18'h2004] ^ hash_b(18'h2004)}, 32'hAB);

    // Simultaneous fetch + half load: LSB first
    poke(32'h3000, 8'hEF); poke(32'h3001, 8'hBE);
    run_scn("both", 1, 32'h0, 1, 0, 2'd1, 32'h3000, 0, -1, 0);
    check_eq("both/lsb_data", lsb_data_out, 32'h0000_BEEF);
    if (obs_if.size() > 0 && obs_lsb.size() > 0)
      check_eq("both/order", {31'd0, obs_lsb[0].e < obs_if[0].e}, 32'd1);

    // Rollback while fetch byte 2 is captured, then a clean fetch
    held = last_exp_if;
    run_scn("rb_fetch", 1, 32'h1000, 0, 0, 2'd0, 0, 0, 5, 0);
    check_eq("rb_fetch/no_ready", obs_if.size(), 0);
    check_eq("rb_fetch/hold", if_instruction_out, held);
    run_scn("fetch2", 1, 32'h2000, 0, 0, 2'd0, 0, 0, -1, 0);

    // Blocked IO store with a fetch served meanwhile
    run_scn("io_store", 1, 32'h1000, 1, 1, 2'd0, 32'h0003_0000, 32'h41, -1, 3);
    if (obs_wr.size() > 0) check_eq("io_store/after_full", {31'd0, obs_wr[0].e >= last_e0 + 3}, 32'd1);

    // Rollback during a word store: it still completes
    run_scn("rb_store", 0, 0, 1, 1, 2'd2, 32'h100, 32'h1122_3344, 2, 0);
    check_eq("rb_store/ram3", {24'd0, ram[18'h103] ^ hash_b(18'h103)}, 32'h11);

    // Wrap-around word load
    run_scn("wrap", 0, 0, 1, 0, 2'd2, 32'hFFFF_FFFE, 0, -1, 0);

    for (int s = 0; s < 40; s++) begin
      r_if  = 1'($urandom_range(0, 1));
      r_lsb = 1'($urandom_range(0, 1));
      if (!r_if && !r_lsb) r_lsb = 1'b1;
      r_rw   = 1'($urandom_range(0, 1));
      r_sz   = 2'($urandom_range(0, 2));
      r_rb   = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 12)) : -1;
      r_full = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_scn("rnd", r_if, rnd_addr(), r_lsb, r_rw, r_sz, rnd_addr(), $urandom, r_rb, r_full);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
